// File: rtl/definitions_pkg.sv
// Shared image geometry and frame-sequencer types for the pixel front end.
package definitions_pkg;

  localparam int unsigned IMAGE_WIDTH   = 512;
  localparam int unsigned IMAGE_HEIGHT  = 512;
  localparam int unsigned NUM_LINE_BUFS = 4;
  localparam int unsigned WINDOW_LINES  = 3;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    STREAM,
    DRAIN,
    DONE
  } feed_state_t;

endpackage

// File: rtl/line_credit_tracker.sv
// Write/read line bookkeeping for the loader's line buffers; decides whether
// a new line may start without overwriting the buffer being read.
module line_credit_tracker
  import definitions_pkg::*;
#(
  parameter int unsigned IMG_W    = IMAGE_WIDTH,
  parameter int unsigned IMG_H    = IMAGE_HEIGHT,
  parameter int unsigned NUM_LBUF = NUM_LINE_BUFS,
  localparam int unsigned ColW    = $clog2(IMG_W),
  localparam int unsigned LineW   = $clog2(IMG_H) + 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [LineW-1:0] wr_lines,
  output logic [ColW-1:0]  rd_col,
  output logic [LineW-1:0] rd_lines,
  output logic             wr_wrap,
  output logic             rd_wrap,
  output logic             room
);

  logic [ColW-1:0]  wr_col_q, rd_col_q;
  logic [LineW-1:0] wr_lines_q, rd_lines_q;
  logic [LineW-1:0] occ;
  logic             line_open;

  assign wr_wrap   = wr_en && (wr_col_q == ColW'(IMG_W - 1));
  assign rd_wrap   = rd_en && (rd_col_q == ColW'(IMG_W - 1));
  assign line_open = (wr_col_q != '0);

  // A partially written line already owns a buffer.
  assign occ  = wr_lines_q - rd_lines_q + LineW'(line_open);
  assign room = line_open || (occ < LineW'(NUM_LBUF));

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_col_q   <= '0;
      wr_lines_q <= '0;
      rd_col_q   <= '0;
      rd_lines_q <= '0;
    end else begin
      if (wr_en) wr_col_q <= wr_wrap ? '0 : wr_col_q + ColW'(1);
      if (wr_wrap) wr_lines_q <= wr_lines_q + LineW'(1);
      if (rd_en) rd_col_q <= rd_wrap ? '0 : rd_col_q + ColW'(1);
      if (rd_wrap) rd_lines_q <= rd_lines_q + LineW'(1);
    end
  end

  assign wr_lines = wr_lines_q;
  assign rd_col   = rd_col_q;
  assign rd_lines = rd_lines_q;

endmodule

// File: rtl/pixel_feed_ctrl.sv
// Frame sequencer in front of pixel_loader: throttles upstream pixels, tags
// output windows with row/column and resets the loader between frames.
module pixel_feed_ctrl
  import definitions_pkg::*;
#(
  parameter int unsigned IMG_W     = IMAGE_WIDTH,
  parameter int unsigned IMG_H     = IMAGE_HEIGHT,
  parameter int unsigned NUM_LBUF  = NUM_LINE_BUFS,
  parameter int unsigned WIN_LINES = WINDOW_LINES
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     start,
  input  logic                     abort,
  input  logic [7:0]               s_pixel,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [7:0]               pl_pixel,
  output logic                     pl_valid,
  output logic                     pl_rstN,
  input  logic                     pl_out_valid,
  output logic [$clog2(IMG_H)-1:0] out_row,
  output logic [$clog2(IMG_W)-1:0] out_col,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     err
);

  localparam int unsigned ColW  = $clog2(IMG_W);
  localparam int unsigned RowW  = $clog2(IMG_H);
  localparam int unsigned LineW = RowW + 1;
  localparam int unsigned Total = IMG_W * IMG_H;
  localparam int unsigned TotW  = $clog2(Total) + 1;

  feed_state_t      state_q, state_d;
  logic [TotW-1:0]  wr_pix_total_q;
  logic             err_q, loader_rst_n_q;
  logic [RowW-1:0]  row_hold_q;
  logic [ColW-1:0]  col_hold_q;
  logic [LineW-1:0] wr_lines, rd_lines;
  logic [ColW-1:0]  rd_col;
  logic             wr_wrap, rd_wrap, room, clr, rd_en, total_full;

  assign clr        = rstN || (state_q == DONE);
  assign total_full = (wr_pix_total_q == TotW'(Total));
  assign s_ready    = (state_q inside {PRIME, STREAM}) && !total_full && room;
  assign pl_valid   = s_valid && s_ready;
  assign pl_pixel   = s_pixel;
  assign rd_en      = pl_out_valid && (state_q inside {STREAM, DRAIN});

  line_credit_tracker #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .NUM_LBUF(NUM_LBUF)
  ) u_credit (
    .clk     (clk),
    .clr     (clr),
    .wr_en   (pl_valid),
    .rd_en   (rd_en),
    .wr_lines(wr_lines),
    .rd_col  (rd_col),
    .rd_lines(rd_lines),
    .wr_wrap (wr_wrap),
    .rd_wrap (rd_wrap),
    .room    (room)
  );

  // Transitions look at the completing beat so the state tracks the counters
  // without an extra cycle of lag.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = PRIME;
      PRIME:  if (wr_lines >= LineW'(WIN_LINES) ||
                  (wr_wrap && wr_lines == LineW'(WIN_LINES - 1))) state_d = STREAM;
      STREAM: if (total_full) state_d = DRAIN;
      DRAIN:  if (rd_lines >= LineW'(IMG_H - 2) ||
                  (rd_wrap && rd_lines == LineW'(IMG_H - 3))) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q inside {PRIME, STREAM, DRAIN})) state_d = DONE;
  end

  always_ff @(posedge clk) begin
    if (rstN) begin
      state_q        <= IDLE;
      wr_pix_total_q <= '0;
      err_q          <= 1'b0;
      loader_rst_n_q <= 1'b0;
      row_hold_q     <= '0;
      col_hold_q     <= '0;
    end else begin
      state_q        <= state_d;
      loader_rst_n_q <= (state_d != DONE);
      if (state_q == DONE) wr_pix_total_q <= '0;
      else if (pl_valid) wr_pix_total_q <= wr_pix_total_q + TotW'(1);
      if ((pl_out_valid && (state_q inside {IDLE, PRIME})) ||
          (rd_wrap && rd_lines >= LineW'(IMG_H - 2))) err_q <= 1'b1;
      if (pl_out_valid) begin
        row_hold_q <= rd_lines[RowW-1:0];
        col_hold_q <= rd_col;
      end
    end
  end

  assign out_row    = pl_out_valid ? rd_lines[RowW-1:0] : row_hold_q;
  assign out_col    = pl_out_valid ? rd_col : col_hold_q;
  assign busy       = state_q inside {PRIME, STREAM, DRAIN};
  assign frame_done = (state_q == DONE);
  assign pl_rstN    = loader_rst_n_q;
  assign err        = err_q;

endmodule

// File: tb/tb_pixel_feed_ctrl.sv
// Self-checking bench for pixel_feed_ctrl with a behavioural loader model.
module tb_pixel_feed_ctrl;

  localparam int W = 512;
  localparam int H = 8;
  localparam int TOTAL = W * H;

  logic       clk = 1'b0;
  logic       rstN, start, abort, s_valid, pl_out_valid;
  logic [7:0] s_pixel, pl_pixel;
  logic       s_ready, pl_valid, pl_rstN, busy, frame_done, err;
  logic [2:0] out_row;
  logic [8:0] out_col;

  int checks = 0;
  int errors = 0;

  // Loader model: lines stored, window being emitted, beat within it.
  int m_lines, m_col, m_wins, m_beat, m_acc;

  always #5 clk = ~clk;

  pixel_feed_ctrl #(
    .IMG_W(W),
    .IMG_H(H)
  ) dut (
    .clk         (clk),
    .rstN        (rstN),
    .start       (start),
    .abort       (abort),
    .s_pixel     (s_pixel),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .pl_pixel    (pl_pixel),
    .pl_valid    (pl_valid),
    .pl_rstN     (pl_rstN),
    .pl_out_valid(pl_out_valid),
    .out_row     (out_row),
    .out_col     (out_col),
    .busy        (busy),
    .frame_done  (frame_done),
    .err         (err)
  );

  typedef struct {
    logic start, abort, s_valid;
    logic busy, ready, done, plrst;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_lines = 0; m_col = 0; m_wins = 0; m_beat = 0;
  endtask

  // Entered at a negedge with the DUT idle; returns at a negedge after DONE.
  task automatic run_frame(input int valid_pct, input int hold, input int abort_at,
                           input string tag);
    int last_beat_cyc, done_cyc, abort_cyc, wins_at_done;
    int bad_valid, bad_pix, bad_tag, overrun;
    logic cap_pv, cap_ov, cap_rst;
    last_beat_cyc = -1; done_cyc = -1; abort_cyc = -1; wins_at_done = -1;
    bad_valid = 0; bad_pix = 0; bad_tag = 0; overrun = 0;
    model_clear();
    m_acc = 0;
    start = 1'b1; abort = 1'b0; s_valid = 1'b0; pl_out_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 20000 && done_cyc < 0; cyc++) begin
      s_valid      = ($urandom_range(99) < valid_pct);
      s_pixel      = 8'($urandom);
      pl_out_valid = (cyc >= hold) && (m_wins < H - 2) && (m_lines >= m_wins + 3);
      abort        = (abort_at > 0) && (abort_cyc < 0) && (m_acc == abort_at);
      if (abort) abort_cyc = cyc;
      #1;
      if (pl_valid !== (s_valid & s_ready)) bad_valid++;
      if (pl_valid && (pl_pixel !== s_pixel)) bad_pix++;
      if (pl_out_valid && (int'(out_row) != m_wins || int'(out_col) != m_beat)) bad_tag++;
      if (valid_pct == 100 && cyc == 1536) check({tag, " prime no stall"}, m_acc, 1536);
      if (hold > 0 && cyc == hold - 1) begin
        check({tag, " held accepted"}, m_acc, 4 * W);
        check({tag, " held s_ready"}, int'(s_ready), 0);
      end
      if (frame_done) begin
        done_cyc     = cyc;
        wins_at_done = m_wins;
        check({tag, " pl_rstN at done"}, int'(pl_rstN), 0);
      end
      cap_pv = pl_valid; cap_ov = pl_out_valid; cap_rst = pl_rstN;
      @(posedge clk);
      if (!cap_rst) begin
        model_clear();
      end else begin
        if (cap_pv) begin
          if (m_col == 0 && m_lines - m_wins >= 4) overrun++;
          m_acc++;
          m_col++;
          if (m_col == W) begin m_col = 0; m_lines++; end
        end
        if (cap_ov) begin
          if (m_wins == H - 3 && m_beat == W - 1) last_beat_cyc = cyc;
          m_beat++;
          if (m_beat == W) begin m_beat = 0; m_wins++; end
        end
      end
      @(negedge clk);
    end
    s_valid = 1'b0; pl_out_valid = 1'b0; abort = 1'b0;
    #1;
    check({tag, " frame_done seen"}, int'(done_cyc >= 0), 1);
    check({tag, " pl_valid rule"}, bad_valid, 0);
    check({tag, " pixel passthru"}, bad_pix, 0);
    check({tag, " overrun"}, overrun, 0);
    check({tag, " err"}, int'(err), 0);
    if (abort_at == 0) begin
      check({tag, " accepted"}, m_acc, TOTAL);
      check({tag, " windows"}, wins_at_done, H - 2);
      check({tag, " row/col tags"}, bad_tag, 0);
      check({tag, " done latency"}, done_cyc - last_beat_cyc, 1);
      check({tag, " final out_row"}, int'(out_row), H - 3);
      check({tag, " final out_col"}, int'(out_col), W - 1);
    end else begin
      check({tag, " done after abort"}, done_cyc - abort_cyc, 1);
      check({tag, " idle s_ready"}, int'(s_ready), 0);
      check({tag, " idle busy"}, int'(busy), 0);
    end
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};  // abort in IDLE ignored
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};  // start beats abort
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};  // start in DONE ignored
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rstN = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b1; s_pixel = 8'h00;
    pl_out_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("reset s_ready", int'(s_ready), 0);
    check("reset pl_valid", int'(pl_valid), 0);
    check("reset busy", int'(busy), 0);
    check("reset frame_done", int'(frame_done), 0);
    check("reset err", int'(err), 0);
    check("reset pl_rstN", int'(pl_rstN), 0);
    rstN = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    check("pl_rstN release", int'(pl_rstN), 1);

    for (int i = 0; i < 10; i++) begin
      start = tbl[i].start; abort = tbl[i].abort; s_valid = tbl[i].s_valid;
      @(negedge clk);
      check($sformatf("vec%0d busy", i), int'(busy), int'(tbl[i].busy));
      check($sformatf("vec%0d s_ready", i), int'(s_ready), int'(tbl[i].ready));
      check($sformatf("vec%0d frame_done", i), int'(frame_done), int'(tbl[i].done));
      check($sformatf("vec%0d pl_rstN", i), int'(pl_rstN), int'(tbl[i].plrst));
      check($sformatf("vec%0d pl_valid", i), int'(pl_valid),
            int'(tbl[i].s_valid & tbl[i].ready));
    end
    start = 1'b0; abort = 1'b0; s_valid = 1'b0;
    @(negedge clk);

    run_frame(100, 0, 0, "nominal");
    run_frame(100, 0, 0, "b2b");
    run_frame(100, 2600, 0, "slow");
    run_frame(50, 0, 0, "bursty");
    run_frame(100, 0, 2000, "abort");

    // Loader output while idle is a protocol error and must stick.
    pl_out_valid = 1'b1;
    @(negedge clk);
    pl_out_valid = 1'b0;
    check("err set in idle", int'(err), 1);
    repeat (5) @(negedge clk);
    check("err sticky", int'(err), 1);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0; s_valid = 1'b1;
    repeat (1800) @(negedge clk);
    check("mid-stream busy", int'(busy), 1);
    rstN = 1'b1;
    @(negedge clk);
    check("midrst s_ready", int'(s_ready), 0);
    check("midrst pl_valid", int'(pl_valid), 0);
    check("midrst busy", int'(busy), 0);
    check("midrst frame_done", int'(frame_done), 0);
    check("midrst err", int'(err), 0);
    check("midrst pl_rstN", int'(pl_rstN), 0);
    check("midrst out_row", int'(out_row), 0);
    check("midrst out_col", int'(out_col), 0);
    rstN = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    check("midrst pl_rstN release", int'(pl_rstN), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
